serial_word_capture: RTL and testbench
======================================

Name: serial_word_capture

Overview:
- Receive end of the serial logic-processor datapath. Its counterpart control FSM asserts a shift enable for a contiguous burst while registers A and B shift out LSB-first, one bit per cycle each.
- This block samples both serial streams under the shift enable and reassembles them into two parallel words.
- It presents the words with a valid/ack handshake and flags truncated bursts and unconsumed words.

Parameters:
WIDTH, 8, bits per frame (shift cycles per burst); legal range 2..16

Ports:
Clk  input  1  system clock, all state on rising edge
Reset_n  input  1  asynchronous active-low reset
Shift_En  input  1  burst qualifier from sender; high = A_sin/B_sin carry a valid bit this cycle
A_sin  input  1  serial bit from register A (LSB first)
B_sin  input  1  serial bit from register B (LSB first)
Ack  input  1  consumer accepts current word; meaningful only while Valid=1
A_out  output  WIDTH  last completed word for A
B_out  output  WIDTH  last completed word for B
Valid  output  1  A_out/B_out hold an unconsumed word
Busy  output  1  frame capture in progress
Frame_Err  output  1  one-cycle pulse: burst ended before WIDTH bits
Overrun  output  1  sticky: a completed frame was dropped because the previous word was still unconsumed

Behaviour:
- Reset (Reset_n low, asynchronous): state IDLE, bit counter 0, shift registers 0, A_out=B_out=0, Valid=0, Busy=0, Frame_Err=0, Overrun=0. Takes effect immediately, including mid-frame. The frame is discarded.
- Capture FSM states are IDLE and SHIFT. The counter is ceil(log2(WIDTH))+1 bits.
- Every edge with Shift_En=1 does a shift-in: sr_a <= {A_sin, sr_a[WIDTH-1:1]}, and likewise for B.
- After WIDTH shift-ins, bit 0 of the word holds the first-received bit. This matches the sender's right-shift order.
- IDLE, Shift_En=1: shift-in, count=1, go to SHIFT.
- IDLE, Shift_En=0: hold.
- SHIFT, Shift_En=1, count<WIDTH-1: shift-in, count+1.
- SHIFT, Shift_En=1, count==WIDTH-1 (completing edge): the completed word, including this bit, goes to the output stage. Count=0, go to IDLE.
- SHIFT, Shift_En=0: abort the frame. Go to IDLE, count=0, Frame_Err=1 for exactly the next cycle. Outputs, Valid and Overrun are unchanged.
- Busy = (state==SHIFT), registered.
- Latency: the first bit is sampled at edge k. Valid and the new words are visible after edge k+WIDTH-1, i.e. WIDTH edges with no gaps.
- A new burst may start on the edge immediately after a completing edge (back-to-back frames).
- Output stage on a completing edge:
  - Valid=0: load A_out/B_out, Valid<=1.
  - Valid=1 and Ack=1 on the same edge: load the new word, Valid stays 1, no overrun.
  - Valid=1 and Ack=0: new word dropped, A_out/B_out unchanged, Overrun<=1.
- Ack on a non-completing edge with Valid=1: Valid<=0. A_out/B_out keep their value.
- Ack while Valid=0: ignored.
- Overrun is cleared only by reset.
- Frame_Err and a completing edge cannot coincide.
- Ack does not affect the capture FSM.
- No combinational path from any input to any output. All outputs are registered.

Test Plan:
1. Reset: apply Reset_n=0 mid-simulation without a clock edge -> all outputs 0 immediately. Release, idle 5 cycles -> outputs stay 0.
2. Single frame:
   - Stimulus: Shift_En=1 for 8 cycles; A_sin=bits of 0xA5 and B_sin=bits of 0x3C, LSB first.
   - Busy=1 for 7 cycles, then Valid=1 with A_out=0xA5, B_out=0x3C.
   - Held with no Ack for 10 cycles; Ack pulse -> Valid=0 next cycle, data retained.
3. Truncated burst:
   - Shift_En high for 5 cycles then low -> Frame_Err high for exactly 1 cycle, Valid stays 0, Busy drops.
   - A following full frame 0x81/0x7E -> A_out=0x81, B_out=0x7E, no stale bits.
4. Overrun:
   - Two back-to-back frames 0x11/0x22 then 0x33/0x44, no Ack -> Valid=1, outputs 0x11/0x22, Overrun=1 sticky.
   - Repeat after reset with Ack on the second frame's completing edge -> outputs 0x33/0x44, Valid=1, Overrun=0.
5. Reset mid-frame: Reset_n low after 3 bits -> Busy=0 immediately. Release, send 0xFF/0x00 -> correct words, no Frame_Err.
6. Parameter: WIDTH=4, frame 0xA/0x5 -> Valid after 4 edges with A_out=0xA, B_out=0x5.

Source files
------------

// File: rtl/serial_word_capture_if.sv
// Serial capture bus: sender/consumer side (master) and the capture block (slave).
//   Shift_En, A_sin, B_sin : serial burst from the sender, LSB first
//   Ack                    : consumer accepts the presented word
//   A_out, B_out, Valid    : reassembled words and their handshake flag
//   Busy, Frame_Err, Overrun : capture status
interface serial_word_capture_if #(
   parameter int unsigned WIDTH = 8
);
   logic             Shift_En;
   logic             A_sin;
   logic             B_sin;
   logic             Ack;
   logic [WIDTH-1:0] A_out;
   logic [WIDTH-1:0] B_out;
   logic             Valid;
   logic             Busy;
   logic             Frame_Err;
   logic             Overrun;

   modport master (
      output Shift_En, A_sin, B_sin, Ack,
      input  A_out, B_out, Valid, Busy, Frame_Err, Overrun
   );

   modport slave (
      input  Shift_En, A_sin, B_sin, Ack,
      output A_out, B_out, Valid, Busy, Frame_Err, Overrun
   );
endinterface

// File: rtl/serial_word_capture.sv
// Receive end of the serial logic-processor datapath. Samples the A/B serial
// streams while Shift_En is high, reassembles WIDTH-bit words (first bit in
// bit 0) and presents them with a Valid/Ack handshake.
// Ports:
//   Clk     : system clock, rising edge
//   Reset_n : asynchronous active-low reset
//   bus     : slave side of serial_word_capture_if (serial in, words/status out)
module serial_word_capture #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   serial_word_capture_if.slave  bus
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [WIDTH-1:0] sr_a, sr_a_nxt;
   logic [WIDTH-1:0] sr_b, sr_b_nxt;
   logic [WIDTH-1:0] a_out_nxt, b_out_nxt;
   logic             valid_nxt, busy_nxt, ferr_nxt, ovr_nxt;
   logic [WIDTH-1:0] word_a_c, word_b_c;

   // Shift register contents after this edge's shift-in (right shift, MSB in).
   assign word_a_c = {bus.A_sin, sr_a[WIDTH-1:1]};
   assign word_b_c = {bus.B_sin, sr_b[WIDTH-1:1]};

   // Next-state and registered-output logic.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      sr_a_nxt  = sr_a;
      sr_b_nxt  = sr_b;
      a_out_nxt = bus.A_out;
      b_out_nxt = bus.B_out;
      valid_nxt = bus.Valid;
      ovr_nxt   = bus.Overrun;
      ferr_nxt  = 1'b0;

      // Consumer handshake; a completing edge below may reload Valid.
      if (bus.Valid && bus.Ack) begin
         valid_nxt = 1'b0;
      end

      case (state)
         IDLE: begin
            if (bus.Shift_En) begin
               sr_a_nxt  = word_a_c;
               sr_b_nxt  = word_b_c;
               cnt_nxt   = CW'(1);
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (bus.Shift_En) begin
               sr_a_nxt = word_a_c;
               sr_b_nxt = word_b_c;
               if (cnt == CW'(WIDTH - 1)) begin
                  cnt_nxt   = '0;
                  state_nxt = IDLE;
                  // Word is taken unless an unconsumed one is still presented.
                  if (!bus.Valid || bus.Ack) begin
                     a_out_nxt = word_a_c;
                     b_out_nxt = word_b_c;
                     valid_nxt = 1'b1;
                  end else begin
                     ovr_nxt = 1'b1;
                  end
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end else begin
               // Burst ended early: drop the partial frame.
               cnt_nxt   = '0;
               state_nxt = IDLE;
               ferr_nxt  = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase

      busy_nxt = (state_nxt == SHIFT);
   end

   // State and output registers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state         <= IDLE;
         cnt           <= '0;
         sr_a          <= '0;
         sr_b          <= '0;
         bus.A_out     <= '0;
         bus.B_out     <= '0;
         bus.Valid     <= 1'b0;
         bus.Busy      <= 1'b0;
         bus.Frame_Err <= 1'b0;
         bus.Overrun   <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         sr_a          <= sr_a_nxt;
         sr_b          <= sr_b_nxt;
         bus.A_out     <= a_out_nxt;
         bus.B_out     <= b_out_nxt;
         bus.Valid     <= valid_nxt;
         bus.Busy      <= busy_nxt;
         bus.Frame_Err <= ferr_nxt;
         bus.Overrun   <= ovr_nxt;
      end
   end

endmodule

// File: tb/tb_serial_word_capture.sv
// Bench for serial_word_capture: WIDTH=8 and WIDTH=4 instances on one clock,
// expected words queued when a frame is driven and compared when Valid shows.
module tb_serial_word_capture;

   logic Clk = 1'b0;
   logic Reset_n;
   always #5 Clk = ~Clk;

   serial_word_capture_if #(.WIDTH(8)) bus ();
   serial_word_capture_if #(.WIDTH(4)) bus4 ();

   serial_word_capture #(.WIDTH(8)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   serial_word_capture #(.WIDTH(4)) dut4 (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus4)
   );

   int tests_run    = 0;
   int tests_failed = 0;
   bit saw_ferr     = 1'b0;

   logic [15:0] exp_q[$];   // {a, b} words for the WIDTH=8 instance
   logic [7:0]  exp4_q[$];  // {a, b} words for the WIDTH=4 instance

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge Clk);
      #1;
      if (bus.Frame_Err) saw_ferr = 1'b1;
   endtask

   task automatic drive_idle();
      bus.Shift_En  = 1'b0;
      bus.A_sin     = 1'b0;
      bus.B_sin     = 1'b0;
      bus.Ack       = 1'b0;
      bus4.Shift_En = 1'b0;
      bus4.A_sin    = 1'b0;
      bus4.B_sin    = 1'b0;
      bus4.Ack      = 1'b0;
   endtask

   // Pulse reset between clock edges; no edge occurs while it is low.
   task automatic pulse_reset();
      Reset_n = 1'b0;
      #2;
      Reset_n = 1'b1;
      exp_q.delete();
      exp4_q.delete();
      tick();
      saw_ferr = 1'b0;
   endtask

   // Drive one full 8-bit frame, Ack optionally on its completing edge.
   task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                             input logic ack_last, input bit expect_capture,
                             output int busy_cnt);
      busy_cnt = 0;
      if (expect_capture) exp_q.push_back({a, b});
      for (int i = 0; i < 8; i++) begin
         bus.Shift_En = 1'b1;
         bus.A_sin    = a[i];
         bus.B_sin    = b[i];
         bus.Ack      = (i == 7) ? ack_last : 1'b0;
         tick();
         if (bus.Busy) busy_cnt++;
      end
      bus.Shift_En = 1'b0;
      bus.Ack      = 1'b0;
   endtask

   task automatic test_reset();
      int bc;
      logic [7:0] a3;
      a3 = 8'h5a;
      send_frame(8'hff, 8'hff, 1'b0, 1'b0, bc);
      for (int i = 0; i < 3; i++) begin
         bus.Shift_En = 1'b1;
         bus.A_sin    = a3[i];
         tick();
      end
      tests_run++;
      if ({bus.Valid, bus.Busy} !== 2'b11) begin
         tests_failed++;
         $display("FAIL reset_pre: {Valid,Busy}=%b expected 11", {bus.Valid, bus.Busy});
      end
      bus.Shift_En = 1'b0;
      Reset_n = 1'b0;
      #2;
      tests_run++;
      if ({bus.A_out, bus.B_out, bus.Valid, bus.Busy, bus.Frame_Err, bus.Overrun} !== '0) begin
         tests_failed++;
         $display("FAIL reset_async: A=%h B=%h V=%b Bz=%b FE=%b OV=%b expected all 0",
                  bus.A_out, bus.B_out, bus.Valid, bus.Busy, bus.Frame_Err, bus.Overrun);
      end
      Reset_n = 1'b1;
      exp_q.delete();
      for (int i = 0; i < 5; i++) begin
         tick();
         tests_run++;
         if ({bus.A_out, bus.B_out, bus.Valid, bus.Busy, bus.Frame_Err, bus.Overrun,
              bus4.A_out, bus4.B_out, bus4.Valid, bus4.Busy} !== '0) begin
            tests_failed++;
            $display("FAIL reset_idle cycle %0d: A=%h B=%h V=%b Bz=%b A4=%h V4=%b expected 0",
                     i, bus.A_out, bus.B_out, bus.Valid, bus.Busy, bus4.A_out, bus4.Valid);
         end
      end
   endtask

   task automatic test_single_frame();
      int bc;
      logic [15:0] e;
      bit held_ok;
      send_frame(8'ha5, 8'h3c, 1'b0, 1'b1, bc);
      tests_run++;
      if (bc !== 7 || bus.Busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_busy: busy cycles=%0d Busy=%b expected 7 and 0", bc, bus.Busy);
      end
      tests_run++;
      if (bus.Valid !== 1'b1 || exp_q.size() == 0) begin
         tests_failed++;
         $display("FAIL single_valid: Valid=%b queued=%0d expected 1", bus.Valid, exp_q.size());
      end else begin
         e = exp_q.pop_front();
         tests_run++;
         if ({bus.A_out, bus.B_out} !== e) begin
            tests_failed++;
            $display("FAIL single_data: got %h/%h expected %h/%h", bus.A_out, bus.B_out, e[15:8], e[7:0]);
         end
      end
      held_ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.Valid !== 1'b1 || bus.A_out !== 8'ha5 || bus.B_out !== 8'h3c) held_ok = 1'b0;
      end
      tests_run++;
      if (!held_ok) begin
         tests_failed++;
         $display("FAIL single_hold: word not held, V=%b A=%h B=%h expected 1/a5/3c",
                  bus.Valid, bus.A_out, bus.B_out);
      end
      bus.Ack = 1'b1;
      tick();
      bus.Ack = 1'b0;
      tests_run++;
      if (bus.Valid !== 1'b0 || bus.A_out !== 8'ha5 || bus.B_out !== 8'h3c) begin
         tests_failed++;
         $display("FAIL single_ack: V=%b A=%h B=%h expected 0/a5/3c", bus.Valid, bus.A_out, bus.B_out);
      end
   endtask

   task automatic test_truncated();
      int bc;
      logic [15:0] e;
      for (int i = 0; i < 5; i++) begin
         bus.Shift_En = 1'b1;
         bus.A_sin    = 1'($urandom_range(1));
         bus.B_sin    = 1'($urandom_range(1));
         tick();
      end
      bus.Shift_En = 1'b0;
      tick();
      tests_run++;
      if ({bus.Frame_Err, bus.Busy, bus.Valid} !== 3'b100) begin
         tests_failed++;
         $display("FAIL trunc_err: {FE,Busy,Valid}=%b expected 100", {bus.Frame_Err, bus.Busy, bus.Valid});
      end
      tick();
      tests_run++;
      if (bus.Frame_Err !== 1'b0) begin
         tests_failed++;
         $display("FAIL trunc_pulse: Frame_Err=%b expected 0 one cycle later", bus.Frame_Err);
      end
      send_frame(8'h81, 8'h7e, 1'b0, 1'b1, bc);
      tests_run++;
      if (bus.Valid !== 1'b1 || exp_q.size() == 0) begin
         tests_failed++;
         $display("FAIL trunc_next_valid: Valid=%b expected 1", bus.Valid);
      end else begin
         e = exp_q.pop_front();
         tests_run++;
         if ({bus.A_out, bus.B_out} !== e) begin
            tests_failed++;
            $display("FAIL trunc_next_data: got %h/%h expected %h/%h", bus.A_out, bus.B_out, e[15:8], e[7:0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int bc;
      logic [15:0] e;
      pulse_reset();
      send_frame(8'h11, 8'h22, 1'b0, 1'b1, bc);
      send_frame(8'h33, 8'h44, 1'b0, 1'b0, bc);
      tests_run++;
      if ({bus.Valid, bus.Overrun} !== 2'b11 || exp_q.size() == 0) begin
         tests_failed++;
         $display("FAIL ovr_flags: {Valid,Overrun}=%b expected 11", {bus.Valid, bus.Overrun});
      end else begin
         e = exp_q.pop_front();
         tests_run++;
         if ({bus.A_out, bus.B_out} !== e) begin
            tests_failed++;
            $display("FAIL ovr_data: got %h/%h expected %h/%h", bus.A_out, bus.B_out, e[15:8], e[7:0]);
         end
      end
      bus.Ack = 1'b1;
      tick();
      bus.Ack = 1'b0;
      tick();
      tick();
      tests_run++;
      if ({bus.Valid, bus.Overrun} !== 2'b01) begin
         tests_failed++;
         $display("FAIL ovr_sticky: {Valid,Overrun}=%b expected 01", {bus.Valid, bus.Overrun});
      end

      pulse_reset();
      send_frame(8'h11, 8'h22, 1'b0, 1'b1, bc);
      tests_run++;
      if (bus.Valid !== 1'b1 || exp_q.size() == 0) begin
         tests_failed++;
         $display("FAIL b2b_first_valid: Valid=%b expected 1", bus.Valid);
      end else begin
         e = exp_q.pop_front();
         tests_run++;
         if ({bus.A_out, bus.B_out} !== e) begin
            tests_failed++;
            $display("FAIL b2b_first_data: got %h/%h expected %h/%h", bus.A_out, bus.B_out, e[15:8], e[7:0]);
         end
      end
      send_frame(8'h33, 8'h44, 1'b1, 1'b1, bc);
      tests_run++;
      if ({bus.Valid, bus.Overrun} !== 2'b10 || exp_q.size() == 0) begin
         tests_failed++;
         $display("FAIL b2b_ack_flags: {Valid,Overrun}=%b expected 10", {bus.Valid, bus.Overrun});
      end else begin
         e = exp_q.pop_front();
         tests_run++;
         if ({bus.A_out, bus.B_out} !== e) begin
            tests_failed++;
            $display("FAIL b2b_ack_data: got %h/%h expected %h/%h", bus.A_out, bus.B_out, e[15:8], e[7:0]);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int bc;
      logic [15:0] e;
      bus.Ack = 1'b1;
      tick();
      bus.Ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.Shift_En = 1'b1;
         bus.A_sin    = 1'b1;
         bus.B_sin    = 1'b1;
         tick();
      end
      bus.Shift_En = 1'b0;
      Reset_n = 1'b0;
      #2;
      tests_run++;
      if (bus.Busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_reset_busy: Busy=%b expected 0", bus.Busy);
      end
      Reset_n = 1'b1;
      exp_q.delete();
      tick();
      saw_ferr = 1'b0;
      send_frame(8'hff, 8'h00, 1'b0, 1'b1, bc);
      tick();
      tests_run++;
      if (saw_ferr !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_reset_ferr: Frame_Err seen=%b expected 0", saw_ferr);
      end
      tests_run++;
      if (bus.Valid !== 1'b1 || exp_q.size() == 0) begin
         tests_failed++;
         $display("FAIL mid_reset_valid: Valid=%b expected 1", bus.Valid);
      end else begin
         e = exp_q.pop_front();
         tests_run++;
         if ({bus.A_out, bus.B_out} !== e) begin
            tests_failed++;
            $display("FAIL mid_reset_data: got %h/%h expected %h/%h", bus.A_out, bus.B_out, e[15:8], e[7:0]);
         end
      end
   endtask

   task automatic test_width4();
      logic [3:0] a, b;
      logic [7:0] e;
      a = 4'ha;
      b = 4'h5;
      exp4_q.push_back({a, b});
      for (int i = 0; i < 4; i++) begin
         bus4.Shift_En = 1'b1;
         bus4.A_sin    = a[i];
         bus4.B_sin    = b[i];
         tick();
         if (i < 3) begin
            tests_run++;
            if (bus4.Valid !== 1'b0 || bus4.Busy !== 1'b1) begin
               tests_failed++;
               $display("FAIL w4_early edge %0d: Valid=%b Busy=%b expected 0/1", i, bus4.Valid, bus4.Busy);
            end
         end
      end
      bus4.Shift_En = 1'b0;
      tests_run++;
      if (bus4.Valid !== 1'b1 || exp4_q.size() == 0) begin
         tests_failed++;
         $display("FAIL w4_valid: Valid=%b expected 1 after 4 edges", bus4.Valid);
      end else begin
         e = exp4_q.pop_front();
         tests_run++;
         if ({bus4.A_out, bus4.B_out} !== e) begin
            tests_failed++;
            $display("FAIL w4_data: got %h/%h expected %h/%h", bus4.A_out, bus4.B_out, e[7:4], e[3:0]);
         end
      end
   endtask

   initial begin
      Reset_n = 1'b0;
      drive_idle();
      #12;
      Reset_n = 1'b1;
      tick();
      tick();
      test_reset();
      test_single_frame();
      test_truncated();
      test_back_to_back();
      test_reset_mid_frame();
      test_width4();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
